qracc_sram_seq: RTL and testbench
=================================

Name: qracc_sram_seq

Overview:
- Digital-to-analog SRAM access sequencer for the QRAcc macro.
- Sits downstream of the controller's sram_itf master port and upstream of the analog array.
- Turns single read/write requests into timed PCH / WL / WRITE / SAEN phases.
- Captures the sense-amp outputs and returns read data on the same handshake bus.

Parameters:
- NUM_ROWS, 128, number of wordlines; address width is $clog2(NUM_ROWS).
- NUM_COLS, 32, number of bitline columns and data word width.
- PCH_CYCLES, 1, precharge phase length in clocks, must be ≥1.
- WL_CYCLES, 2, wordline-active phase length in clocks, must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- rq_wr_i  in  1  1 = write request, 0 = read request.
- rq_valid_i  in  1  request valid.
- rq_ready_o  out  1  request accepted when rq_valid_i & rq_ready_o are both 1.
- rd_valid_o  out  1  one-cycle pulse; rd_data_o is valid during this cycle.
- rd_data_o  out  NUM_COLS  read data.
- wr_data_i  in  NUM_COLS  write data.
- addr_i  in  $clog2(NUM_ROWS)  row address.
- WL  out  NUM_ROWS  one-hot wordline.
- PCH  out  1  bitline precharge.
- WR_DATA  out  NUM_COLS  bitline write data.
- WRITE  out  1  write driver enable.
- CSEL  out  NUM_COLS  column select.
- SAEN  out  1  sense-amp enable.
- SA_OUT  in  NUM_COLS  sense-amp outputs from analog.
- wr_err_o  out  1  write-verify mismatch flag; present only with the optional feature.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All outputs go to 0 immediately, except rq_ready_o, which goes to 1.
  - FSM goes to IDLE; internal registers clear.
  - Reset mid-operation aborts the access with no rd_valid_o pulse.
- FSM states: IDLE, PRECHARGE, WORDLINE, SENSE, DONE.
- IDLE:
  - rq_ready_o = 1.
  - On handshake at edge T: latch addr_i, wr_data_i and rq_wr_i into registers, then go to PRECHARGE.
  - rq_ready_o = 0 in every state other than IDLE.
- PRECHARGE:
  - PCH = 1 for PCH_CYCLES clocks (cycles T+1..T+P); a down-counter tracks the phase.
  - WL, WRITE and SAEN are 0. PCH is never high in the same cycle as WL.
- WORDLINE:
  - WL[addr] = 1 for WL_CYCLES clocks (T+P+1..T+P+W).
  - CSEL = all ones.
  - Write: WRITE = 1 and WR_DATA = latched data; then return to IDLE, with rq_ready_o = 1 at T+P+W+1.
  - Read: WRITE = 0, WR_DATA = 0; then go to SENSE.
- SENSE (read only):
  - One cycle at T+P+W+1: WL stays asserted, SAEN = 1.
  - SA_OUT is registered at the edge ending this cycle.
- DONE (read only):
  - Cycle T+P+W+2: rd_valid_o = 1, rd_data_o = captured SA_OUT.
  - WL, SAEN and CSEL are 0. Next state is IDLE.
  - rd_data_o holds its value until the next capture.
- Default latency: read pulse at T+5; write returns ready at T+4.
- Out-of-range address (addr ≥ NUM_ROWS, possible only when NUM_ROWS is not a power of 2):
  - The request is accepted and phases run normally, but WL stays all-zero.
  - A read returns 0 instead of SA_OUT.
- rq_valid_i asserted in a non-IDLE state is ignored (no queue).
- Back-to-back accesses: the next request can be accepted in the cycle after the write phase ends, or in the cycle after the DONE cycle.
- All analog outputs are registered; they are glitch-free, one-hot WL.

Optional Feature:
- Macro: QRACC_SRAM_WR_VERIFY_EN.
- Defined:
  - Port wr_err_o exists.
  - After a write's WORDLINE phase, the FSM runs PRECHARGE → WORDLINE(read) → SENSE on the same address, with no rd_valid_o pulse.
  - It compares the captured SA_OUT with the latched write data, then returns to IDLE.
  - wr_err_o is sticky high on mismatch and clears only on rst.
  - Write latency becomes T+2P+2W+2 for the return to rq_ready_o = 1.
- Undefined:
  - wr_err_o is absent.
  - Writes end after the WORDLINE phase as described above.

Test Plan:
- Reset check: assert rst mid-PRECHARGE → same-cycle PCH = 0, WL = 0, rq_ready_o = 1; no rd_valid_o pulse afterwards.
- Write: write addr = 5, wr_data_i = 0xA5A5_0F0F at T → PCH high at T+1; WL = 1<<5, WRITE = 1, WR_DATA = 0xA5A5_0F0F at T+2..T+3; rq_ready_o = 1 at T+4.
- Read: read addr = 127 with SA_OUT = 0xDEAD_BEEF driven → SAEN = 1 at T+4 only; rd_valid_o = 1 with rd_data_o = 0xDEAD_BEEF at T+5; PCH and WL never overlap.
- Ignored request: hold rq_valid_i = 1 throughout a read with changing addr_i → only the first address is used; second handshake at T+6.
- Non-default timing: PCH_CYCLES = 3, WL_CYCLES = 4, read addr = 0 → PCH T+1..T+3, WL[0] T+4..T+8, SAEN at T+8, rd_valid_o at T+9.
- Write-verify (QRACC_SRAM_WR_VERIFY_EN): write 0x1234_5678 with SA_OUT stuck at 0x1234_5679 → wr_err_o rises after the verify SENSE and stays 1 across later good writes until rst.

Source files
------------

// File: rtl/qracc_sram_seq_if.sv
// Request / read-data bus between the QRAcc controller and the SRAM sequencer.
// The controller owns the master side; the sequencer is the slave.
interface qracc_sram_seq_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              rq_wr_i;
    logic              rq_valid_i;
    logic              rq_ready_o;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [DATA_W-1:0] wr_data_i;
    logic [ADDR_W-1:0] addr_i;

    modport master (
        output rq_wr_i,
        output rq_valid_i,
        output wr_data_i,
        output addr_i,
        input  rq_ready_o,
        input  rd_valid_o,
        input  rd_data_o
    );

    modport slave (
        input  rq_wr_i,
        input  rq_valid_i,
        input  wr_data_i,
        input  addr_i,
        output rq_ready_o,
        output rd_valid_o,
        output rd_data_o
    );
endinterface

// File: rtl/qracc_sram_seq.sv
// QRAcc SRAM access sequencer: PCH / WL / WRITE / SAEN phase timing per request.
// Define QRACC_SRAM_WR_VERIFY_EN to add a read-back verify after every write.
module qracc_sram_seq #(
    parameter int NUM_ROWS   = 128,
    parameter int NUM_COLS   = 32,
    parameter int PCH_CYCLES = 1,
    parameter int WL_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    qracc_sram_seq_if.slave     bus,
    output logic [NUM_ROWS-1:0] WL,
    output logic                PCH,
    output logic [NUM_COLS-1:0] WR_DATA,
    output logic                WRITE,
    output logic [NUM_COLS-1:0] CSEL,
    output logic                SAEN,
    input  logic [NUM_COLS-1:0] SA_OUT
`ifdef QRACC_SRAM_WR_VERIFY_EN
    ,
    output logic                wr_err_o
`endif
);
    localparam int AW      = $clog2(NUM_ROWS);
    localparam int CNT_MAX = (PCH_CYCLES > WL_CYCLES) ? PCH_CYCLES : WL_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        WORDLINE,
        SENSE,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [AW-1:0]       addr_q;
    logic [NUM_COLS-1:0] data_q;
    logic [NUM_COLS-1:0] rd_data_q;
    logic                wr_q;
    logic                vfy_q;
    logic                ready_q;
    logic                rd_valid_q;
    logic [NUM_ROWS-1:0] wl_dec;
    logic                addr_ok;
    logic [NUM_COLS-1:0] sa_cap;
`ifdef QRACC_SRAM_WR_VERIFY_EN
    logic                wr_err_q;
`endif

    // An out-of-range address decodes to no wordline at all.
    always_comb begin
        wl_dec = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (addr_q == AW'(i)) wl_dec[i] = 1'b1;
        end
    end

    assign addr_ok = 32'(addr_q) < NUM_ROWS;
    assign sa_cap  = addr_ok ? SA_OUT : '0;

    assign bus.rq_ready_o = ready_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
`ifdef QRACC_SRAM_WR_VERIFY_EN
    assign wr_err_o = wr_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            vfy_q      <= 1'b0;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            WL         <= '0;
            PCH        <= 1'b0;
            WR_DATA    <= '0;
            WRITE      <= 1'b0;
            CSEL       <= '0;
            SAEN       <= 1'b0;
`ifdef QRACC_SRAM_WR_VERIFY_EN
            wr_err_q   <= 1'b0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.rq_valid_i) begin
                        addr_q  <= bus.addr_i;
                        data_q  <= bus.wr_data_i;
                        wr_q    <= bus.rq_wr_i;
                        vfy_q   <= 1'b0;
                        ready_q <= 1'b0;
                        PCH     <= 1'b1;
                        cnt     <= CW'(PCH_CYCLES - 1);
                        state   <= PRECHARGE;
                    end
                end
                PRECHARGE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        PCH     <= 1'b0;
                        WL      <= wl_dec;
                        CSEL    <= '1;
                        WRITE   <= wr_q & ~vfy_q;
                        WR_DATA <= (wr_q & ~vfy_q) ? data_q : '0;
                        cnt     <= CW'(WL_CYCLES - 1);
                        state   <= WORDLINE;
                    end
                end
                WORDLINE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        WRITE   <= 1'b0;
                        WR_DATA <= '0;
                        if (wr_q && !vfy_q) begin
                            WL   <= '0;
                            CSEL <= '0;
`ifdef QRACC_SRAM_WR_VERIFY_EN
                            // Re-read the just-written row before releasing the bus.
                            vfy_q <= 1'b1;
                            PCH   <= 1'b1;
                            cnt   <= CW'(PCH_CYCLES - 1);
                            state <= PRECHARGE;
`else
                            ready_q <= 1'b1;
                            state   <= IDLE;
`endif
                        end else begin
                            SAEN  <= 1'b1;
                            state <= SENSE;
                        end
                    end
                end
                SENSE: begin
                    WL   <= '0;
                    CSEL <= '0;
                    SAEN <= 1'b0;
                    if (vfy_q) begin
`ifdef QRACC_SRAM_WR_VERIFY_EN
                        if (sa_cap != data_q) wr_err_q <= 1'b1;
`endif
                        vfy_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        rd_data_q  <= sa_cap;
                        rd_valid_q <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qracc_sram_seq.sv
// Bench for qracc_sram_seq: phase-window model of two instances plus directed vectors.
// Build with +define+QRACC_SRAM_WR_VERIFY_EN to cover the write-verify option.
module tb_qracc_sram_seq;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NI = 2;
`ifdef QRACC_SRAM_WR_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qracc_sram_seq_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    qracc_sram_seq_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    logic [127:0]  wl0;
    logic [99:0]   wl1;
    logic          pch0, pch1, wre0, wre1, saen0, saen1;
    logic [DW-1:0] wrd0, wrd1, csel0, csel1, sa0, sa1;
    logic          err0, err1;

    qracc_sram_seq #(
        .NUM_ROWS(128), .NUM_COLS(DW), .PCH_CYCLES(1), .WL_CYCLES(2)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0),
        .WL(wl0), .PCH(pch0), .WR_DATA(wrd0), .WRITE(wre0),
        .CSEL(csel0), .SAEN(saen0), .SA_OUT(sa0)
`ifdef QRACC_SRAM_WR_VERIFY_EN
        , .wr_err_o(err0)
`endif
    );

    qracc_sram_seq #(
        .NUM_ROWS(100), .NUM_COLS(DW), .PCH_CYCLES(3), .WL_CYCLES(4)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1),
        .WL(wl1), .PCH(pch1), .WR_DATA(wrd1), .WRITE(wre1),
        .CSEL(csel1), .SAEN(saen1), .SA_OUT(sa1)
`ifdef QRACC_SRAM_WR_VERIFY_EN
        , .wr_err_o(err1)
`endif
    );

`ifndef QRACC_SRAM_WR_VERIFY_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    function automatic int pl(int i);   return (i == 0) ? 1 : 3;     endfunction
    function automatic int wll(int i);  return (i == 0) ? 2 : 4;     endfunction
    function automatic int rows(int i); return (i == 0) ? 128 : 100; endfunction
    function automatic bit in_r(int k, int lo, int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    logic [127:0]  wl_a   [NI];
    logic          pch_a  [NI], wre_a [NI], saen_a [NI], err_a [NI];
    logic          rdy_a  [NI], rdv_a [NI], v_a [NI], w_a [NI];
    logic [DW-1:0] wrd_a  [NI], csel_a [NI], rdd_a [NI], sa_a [NI], wd_a [NI];
    logic [AW-1:0] ad_a   [NI];

    always_comb begin
        wl_a[0] = wl0;            wl_a[1] = {28'd0, wl1};
        pch_a[0] = pch0;          pch_a[1] = pch1;
        wre_a[0] = wre0;          wre_a[1] = wre1;
        saen_a[0] = saen0;        saen_a[1] = saen1;
        err_a[0] = err0;          err_a[1] = err1;
        wrd_a[0] = wrd0;          wrd_a[1] = wrd1;
        csel_a[0] = csel0;        csel_a[1] = csel1;
        sa_a[0] = sa0;            sa_a[1] = sa1;
        rdy_a[0] = b0.rq_ready_o; rdy_a[1] = b1.rq_ready_o;
        rdv_a[0] = b0.rd_valid_o; rdv_a[1] = b1.rd_valid_o;
        rdd_a[0] = b0.rd_data_o;  rdd_a[1] = b1.rd_data_o;
        v_a[0] = b0.rq_valid_i;   v_a[1] = b1.rq_valid_i;
        w_a[0] = b0.rq_wr_i;      w_a[1] = b1.rq_wr_i;
        wd_a[0] = b0.wr_data_i;   wd_a[1] = b1.wr_data_i;
        ad_a[0] = b0.addr_i;      ad_a[1] = b1.addr_i;
    end

    // Model: an accepted request at edge T owns the bus for a fixed window of cycles.
    int            cyc = 0;
    bit            busy  [NI];
    int            t0    [NI];
    bit            mwr   [NI];
    int            maddr [NI];
    logic [DW-1:0] mdat  [NI];
    logic [DW-1:0] mrd   [NI];
    bit            merr  [NI];
    int            npass = 0;
    int            nchk  = 0;

    function automatic int dur(int i);
        if (!mwr[i]) return pl(i) + wll(i) + 3;
        return VFY ? 2 * pl(i) + 2 * wll(i) + 2 : pl(i) + wll(i) + 1;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            busy[i] = 1'b0; t0[i] = 0; mwr[i] = 1'b0; maddr[i] = 0;
            mdat[i] = '0; mrd[i] = '0; merr[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int k;
            logic [DW-1:0] seen;
            k = cyc - t0[i];
            seen = (maddr[i] < rows(i)) ? sa_a[i] : '0;
            if (rst) begin
                busy[i] = 1'b0;
                mrd[i]  = '0;
                merr[i] = 1'b0;
            end else if (!busy[i]) begin
                if (v_a[i]) begin
                    busy[i] = 1'b1;  t0[i] = cyc;  mwr[i] = w_a[i];
                    maddr[i] = int'(ad_a[i]);  mdat[i] = wd_a[i];
                end
            end else begin
                if (!mwr[i] && k == pl(i) + wll(i) + 1) mrd[i] = seen;
                if (VFY && mwr[i] && k == 2 * pl(i) + 2 * wll(i) + 1 && seen != mdat[i])
                    merr[i] = 1'b1;
                if (k + 1 >= dur(i)) busy[i] = 1'b0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                int k, p, w;
                bit b, rd, wlon, e_pch, e_wre, e_saen, e_rdv;
                logic [127:0] e_wl;
                k = cyc - t0[i];  p = pl(i);  w = wll(i);
                b = busy[i];
                rd = b && !mwr[i];
                e_pch = b && (in_r(k, 1, p) || (VFY && mwr[i] && in_r(k, p + w + 1, 2 * p + w)));
                wlon = rd ? in_r(k, p + 1, p + w + 1)
                          : (b && (in_r(k, p + 1, p + w) ||
                                  (VFY && in_r(k, 2 * p + w + 1, 2 * p + 2 * w + 1))));
                e_wl = (wlon && maddr[i] < rows(i)) ? (128'(1) << maddr[i]) : '0;
                e_wre = b && mwr[i] && in_r(k, p + 1, p + w);
                e_saen = rd ? (k == p + w + 1) : (b && VFY && k == 2 * p + 2 * w + 1);
                e_rdv = rd && (k == p + w + 2);
                chk($sformatf("u%0d.ready", i), rdy_a[i], !b);
                chk($sformatf("u%0d.pch", i), pch_a[i], e_pch);
                chk($sformatf("u%0d.wl", i), wl_a[i], e_wl);
                chk($sformatf("u%0d.csel", i), csel_a[i], wlon ? 32'hFFFF_FFFF : 32'h0);
                chk($sformatf("u%0d.write", i), wre_a[i], e_wre);
                chk($sformatf("u%0d.wr_data", i), wrd_a[i], e_wre ? mdat[i] : '0);
                chk($sformatf("u%0d.saen", i), saen_a[i], e_saen);
                chk($sformatf("u%0d.rd_valid", i), rdv_a[i], e_rdv);
                chk($sformatf("u%0d.rd_data", i), rdd_a[i], mrd[i]);
                chk($sformatf("u%0d.pch_wl_overlap", i), pch_a[i] && (|wl_a[i]), 1'b0);
`ifdef QRACC_SRAM_WR_VERIFY_EN
                chk($sformatf("u%0d.wr_err", i), err_a[i], merr[i]);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int i);
        int n;
        n = 0;
        while (!((i == 0) ? b0.rq_ready_o : b1.rq_ready_o) && n < 40) begin
            step();
            n++;
        end
        chk($sformatf("u%0d.wait_ready", i), (i == 0) ? b0.rq_ready_o : b1.rq_ready_o, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        b0.rq_valid_i = 1'b0; b0.rq_wr_i = 1'b0; b0.addr_i = '0; b0.wr_data_i = '0;
        b1.rq_valid_i = 1'b0; b1.rq_wr_i = 1'b0; b1.addr_i = '0; b1.wr_data_i = '0;
        sa0 = '0;
        sa1 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.ready", b0.rq_ready_o, 1'b1);
        chk("reset.pch", pch0, 1'b0);
        chk("reset.wl", wl0, 128'h0);
        chk("reset.rd_data", b0.rd_data_o, 32'h0);

        // Write addr 5 on the default instance
        sa0 = 32'hA5A5_0F0F;
        b0.rq_valid_i = 1'b1; b0.rq_wr_i = 1'b1;
        b0.addr_i = 7'd5; b0.wr_data_i = 32'hA5A5_0F0F;
        step();
        b0.rq_valid_i = 1'b0; b0.wr_data_i = '0;
        chk("wr.pch_t1", pch0, 1'b1);
        chk("wr.wl_t1", wl0, 128'h0);
        step();
        chk("wr.wl_t2", wl0, 128'h20);
        chk("wr.write_t2", wre0, 1'b1);
        chk("wr.data_t2", wrd0, 32'hA5A5_0F0F);
        step();
        chk("wr.wl_t3", wl0, 128'h20);
        step();
        chk("wr.ready_t4", b0.rq_ready_o, !VFY);
        chk("wr.wl_t4", wl0, 128'h0);
        wait_rdy(0);

        // Read addr 127
        sa0 = 32'hDEAD_BEEF;
        b0.rq_valid_i = 1'b1; b0.rq_wr_i = 1'b0; b0.addr_i = 7'd127;
        step();
        b0.rq_valid_i = 1'b0;
        step();
        chk("rd.wl_t2", wl0, {1'b1, 127'h0});
        step();
        chk("rd.saen_t3", saen0, 1'b0);
        step();
        chk("rd.saen_t4", saen0, 1'b1);
        chk("rd.wl_t4", wl0, {1'b1, 127'h0});
        step();
        chk("rd.valid_t5", b0.rd_valid_o, 1'b1);
        chk("rd.data_t5", b0.rd_data_o, 32'hDEAD_BEEF);
        chk("rd.model_data_t5", mrd[0], 32'hDEAD_BEEF);
        chk("rd.saen_t5", saen0, 1'b0);
        sa0 = 32'h0;
        step();
        chk("rd.hold_t6", b0.rd_data_o, 32'hDEAD_BEEF);
        chk("rd.valid_t6", b0.rd_valid_o, 1'b0);

        // Held valid with changing address: only the first is used
        sa0 = 32'h0BAD_F00D;
        b0.rq_valid_i = 1'b1; b0.addr_i = 7'd10;
        step();
        b0.addr_i = 7'd21;
        step();
        chk("ign.wl_t2", wl0, 128'h400);
        b0.addr_i = 7'd22;
        step();
        b0.addr_i = 7'd23;
        step();
        b0.addr_i = 7'd24;
        step();
        chk("ign.data_t5", b0.rd_data_o, 32'h0BAD_F00D);
        b0.addr_i = 7'd33;
        step();
        chk("ign.ready_t6", b0.rq_ready_o, 1'b1);
        step();
        b0.rq_valid_i = 1'b0;
        chk("ign.pch_2nd", pch0, 1'b1);
        step();
        chk("ign.wl_2nd", wl0, 128'h2_0000_0000);
        wait_rdy(0);

        // Non-default timing read addr 0
        sa1 = 32'h1357_9BDF;
        b1.rq_valid_i = 1'b1; b1.rq_wr_i = 1'b0; b1.addr_i = 7'd0;
        step();
        b1.rq_valid_i = 1'b0;
        chk("nd.pch_t1", pch1, 1'b1);
        step();
        step();
        chk("nd.pch_t3", pch1, 1'b1);
        step();
        chk("nd.pch_t4", pch1, 1'b0);
        chk("nd.wl_t4", wl_a[1], 128'h1);
        repeat (4) step();
        chk("nd.saen_t8", saen1, 1'b1);
        chk("nd.wl_t8", wl_a[1], 128'h1);
        step();
        chk("nd.valid_t9", b1.rd_valid_o, 1'b1);
        chk("nd.data_t9", b1.rd_data_o, 32'h1357_9BDF);
        wait_rdy(1);

        // Asynchronous reset in the middle of precharge
        sa1 = 32'h2468_ACE0;
        b1.rq_valid_i = 1'b1; b1.addr_i = 7'd1;
        step();
        b1.rq_valid_i = 1'b0;
        step();
        chk("rst.pch_before", pch1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst.pch_same", pch1, 1'b0);
        chk("rst.wl_same", wl_a[1], 128'h0);
        chk("rst.ready_same", b1.rq_ready_o, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            step();
            if (b1.rd_valid_o) pulses++;
        end
        chk("rst.no_rd_valid", pulses, 0);
        chk("rst.rd_data_clear", b1.rd_data_o, 32'h0);

        // Out-of-range read addr 120 on the 100-row instance
        sa1 = 32'hFFFF_FFFF;
        b1.rq_valid_i = 1'b1; b1.addr_i = 7'd120;
        step();
        b1.rq_valid_i = 1'b0;
        repeat (3) step();
        chk("oor.wl_t4", wl_a[1], 128'h0);
        chk("oor.csel_t4", csel1, 32'hFFFF_FFFF);
        repeat (5) step();
        chk("oor.valid_t9", b1.rd_valid_o, 1'b1);
        chk("oor.data_t9", b1.rd_data_o, 32'h0);
        wait_rdy(1);

`ifdef QRACC_SRAM_WR_VERIFY_EN
        // Write-verify with a stuck sense-amp bit
        sa0 = 32'h1234_5679;
        b0.rq_valid_i = 1'b1; b0.rq_wr_i = 1'b1;
        b0.addr_i = 7'd3; b0.wr_data_i = 32'h1234_5678;
        step();
        b0.rq_valid_i = 1'b0;
        repeat (6) step();
        chk("vfy.err_t7", err0, 1'b0);
        chk("vfy.ready_t7", b0.rq_ready_o, 1'b0);
        step();
        chk("vfy.err_t8", err0, 1'b1);
        chk("vfy.ready_t8", b0.rq_ready_o, 1'b1);
        sa0 = 32'hCAFE_0000;
        b0.rq_valid_i = 1'b1; b0.addr_i = 7'd4; b0.wr_data_i = 32'hCAFE_0000;
        step();
        b0.rq_valid_i = 1'b0;
        step();
        wait_rdy(0);
        chk("vfy.err_sticky", err0, 1'b1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("vfy.err_cleared", err0, 1'b0);
`endif

        repeat (3) step();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
